// File: rtl/arbiter_pkg.sv
// Shared types for the round-robin arbiter.
// Holds the ownership states and the hold-counter width.
package arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/encoder.sv
// One-hot to binary encoder.
// An all-zero input yields index 0.
module encoder #(
    parameter int OUT_SIZE = 4,
    localparam int IN_SIZE = 1 << OUT_SIZE
) (
    input  logic [IN_SIZE-1:0]  oh_i,
    output logic [OUT_SIZE-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (oh_i[i]) begin
                bin_o = bin_o | OUT_SIZE'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant.
// An owner keeps the grant until it drops req or its hold budget runs out.
module rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int OUT_SIZE = 4,
    parameter int MAX_HOLD = 8,
    localparam int IN_SIZE = 1 << OUT_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_SIZE-1:0]  req,
    output logic [IN_SIZE-1:0]  grant,
    output logic                grant_valid,
    output logic [OUT_SIZE-1:0] grant_idx
);

    state_e              state_q, state_d;
    logic [IN_SIZE-1:0]  grant_q, grant_d;
    logic [OUT_SIZE-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [IN_SIZE-1:0]  others;
    logic                owner_req;
    logic                hand_off;
    logic [OUT_SIZE-1:0] win;

    // First set bit at or above p, wrapping past the top index.
    function automatic logic [OUT_SIZE-1:0] rr_pick(
        input logic [IN_SIZE-1:0]  r,
        input logic [OUT_SIZE-1:0] p
    );
        logic [OUT_SIZE-1:0] idx;
        logic                found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < IN_SIZE; i++) begin
            idx = p + OUT_SIZE'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        hand_off  = 1'b0;
        win       = '0;
        // Owner bit masked; in IDLE grant_q is zero so this is just req.
        others    = req & ~grant_q;
        owner_req = |(req & grant_q);

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    hand_off = 1'b1;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    if (|others) begin
                        hand_off = 1'b1;
                    end else begin
                        grant_d = '0;
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end else if (|others) begin
                    if (hold_q == HOLD_W'(MAX_HOLD)) begin
                        hand_off = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (hand_off) begin
            win     = rr_pick(others, ptr_q);
            grant_d = {{(IN_SIZE-1){1'b0}}, 1'b1} << win;
            ptr_d   = win + 1'b1;
            hold_d  = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;

    encoder #(
        .OUT_SIZE (OUT_SIZE)
    ) u_encoder (
        .oh_i  (grant_q),
        .bin_o (grant_idx)
    );

endmodule

// File: tb/tb_rr_arbiter.sv
// Testbench for rr_arbiter: directed scenarios plus random traffic
// compared against an ownership/pointer reference model.
module tb_rr_arbiter;

    localparam int OUT_SIZE = 4;
    localparam int MAX_HOLD = 8;
    localparam int N        = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [3:0]    grant_idx;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: current owner (-1 = none), next-scan start, hold cycles
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_arbiter #(
        .OUT_SIZE (OUT_SIZE),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_update(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] oth;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            return;
        end
        oth = r;
        if (m_owner >= 0) oth[m_owner] = 1'b0;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = first_from(r, m_ptr);
                m_ptr   = (m_owner + 1) % N;
                m_hold  = 0;
            end
        end else if (!r[m_owner] || (oth != 0 && m_hold == MAX_HOLD)) begin
            if (oth != 0) begin
                m_owner = first_from(oth, m_ptr);
                m_ptr   = (m_owner + 1) % N;
                m_hold  = 0;
            end else begin
                m_owner = -1;
            end
        end else if (oth != 0) begin
            m_hold = m_hold + 1;
        end
    endfunction

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    // One clock: drive, advance model, sample 1 ns after the edge,
    // and check the grant/grant_idx/grant_valid invariants.
    task automatic step(input logic [N-1:0] r, input logic rs);
        logic [3:0] ei;
        req = r;
        rst = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
        ei = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) ei = ei | 4'(i);
        end
        n_total++;
        if ((grant & (grant - 16'd1)) !== 16'd0)
            $display("FAIL onehot: grant=%h not one-hot or zero", grant);
        else n_pass++;
        n_total++;
        if (grant_idx !== ei)
            $display("FAIL idx_match: grant_idx=%0d expected=%0d", grant_idx, ei);
        else n_pass++;
        n_total++;
        if (grant_valid !== (grant != 0))
            $display("FAIL valid_match: grant_valid=%b grant=%h", grant_valid, grant);
        else n_pass++;
    endtask

    task automatic test_reset();
        step(16'hFFFF, 1'b1);
        step(16'hFFFF, 1'b1);
        n_total++;
        if (grant !== 16'h0 || grant_valid !== 1'b0 || grant_idx !== 4'd0)
            $display("FAIL reset: grant=%h valid=%b idx=%0d expected 0/0/0",
                     grant, grant_valid, grant_idx);
        else n_pass++;
    endtask

    task automatic test_single();
        step(16'h0000, 1'b0);
        step(16'h0001, 1'b0);
        n_total++;
        if (grant !== 16'h0001 || grant_idx !== 4'd0 || grant_valid !== 1'b1)
            $display("FAIL single_grant: grant=%h idx=%0d expected 0001/0", grant, grant_idx);
        else n_pass++;
        step(16'h0000, 1'b0);
        n_total++;
        if (grant !== 16'h0000 || grant_valid !== 1'b0)
            $display("FAIL single_release: grant=%h valid=%b expected 0000/0",
                     grant, grant_valid);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [N-1:0] r;
        step(16'h0000, 1'b1);
        step(16'hFFFF, 1'b0);
        n_total++;
        if (grant_idx !== 4'd0 || grant_valid !== 1'b1)
            $display("FAIL sweep_start: idx=%0d expected 0", grant_idx);
        else n_pass++;
        for (int k = 0; k < N; k++) begin
            r = 16'hFFFF;
            r[k] = 1'b0;
            step(r, 1'b0);
            n_total++;
            if (grant_idx !== 4'((k + 1) % N) || grant_valid !== 1'b1)
                $display("FAIL sweep_%0d: idx=%0d valid=%b expected %0d",
                         k, grant_idx, grant_valid, (k + 1) % N);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int exp_idx;
        step(16'h0000, 1'b1);
        for (int p = 0; p < 40; p++) begin
            step(16'h0005, 1'b0);
            exp_idx = ((p / (MAX_HOLD + 1)) % 2 == 0) ? 0 : 2;
            n_total++;
            if (grant_idx !== 4'(exp_idx) || grant_valid !== 1'b1)
                $display("FAIL timeout_cycle%0d: idx=%0d expected %0d",
                         p, grant_idx, exp_idx);
            else n_pass++;
        end
    endtask

    task automatic test_lone();
        step(16'h0000, 1'b1);
        for (int p = 0; p < 50; p++) begin
            step(16'h8000, 1'b0);
            n_total++;
            if (grant !== 16'h8000)
                $display("FAIL lone_cycle%0d: grant=%h expected 8000", p, grant);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_reset();
        step(16'h0000, 1'b1);
        step(16'h8000, 1'b0);
        n_total++;
        if (grant_idx !== 4'd15)
            $display("FAIL wrap_owner: idx=%0d expected 15", grant_idx);
        else n_pass++;
        step(16'h0008, 1'b0);
        n_total++;
        if (grant !== 16'h0008 || grant_idx !== 4'd3)
            $display("FAIL wrap_handoff: grant=%h expected 0008", grant);
        else n_pass++;
        step(16'h0008, 1'b1);
        n_total++;
        if (grant !== 16'h0000 || grant_valid !== 1'b0 || grant_idx !== 4'd0)
            $display("FAIL midgrant_reset: grant=%h valid=%b expected 0000/0",
                     grant, grant_valid);
        else n_pass++;
        step(16'h0018, 1'b0);
        n_total++;
        if (grant !== 16'h0008 || grant_idx !== 4'd3)
            $display("FAIL post_reset_arb: grant=%h idx=%0d expected 0008/3",
                     grant, grant_idx);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         rs;
        step(16'h0000, 1'b1);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = '0;
                r[$urandom_range(0, N - 1)] = 1'b1;
            end else begin
                r = 16'($urandom) & 16'($urandom);
            end
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            rs = ($urandom_range(0, 63) == 0);
            step(r, rs);
            n_total++;
            if (grant !== model_grant())
                $display("FAIL random_c%0d: req=%h grant=%h expected %h",
                         c, r, grant, model_grant());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_timeout();
        test_lone();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter OUT_SIZE, default 4, width of the encoded grant index.
REQ-002 Parameter IN_SIZE, default 1<<OUT_SIZE, number of requesters; derived, not overridden.
REQ-003 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles while other requests are pending; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  IN_SIZE  request vector, bit i = requester i; any number of bits may be set.
REQ-007 grant  output  IN_SIZE  registered grant, one-hot or all-zero.
REQ-008 grant_valid  output  1  high when grant is nonzero.
REQ-009 grant_idx  output  OUT_SIZE  binary index of the set grant bit; 0 when grant_valid is low.

Function
REQ-010 The block SHALL implement two states: IDLE (no owner) and BUSY (one owner holds grant).
REQ-011 IDLE: on an edge with req nonzero, the block SHALL register a grant to the winner and enter BUSY; a grant is visible one cycle after the request.
REQ-012 Winner selection: first set req bit scanning upward from the priority pointer with wrap-around at IN_SIZE-1 -> 0.
REQ-013 After every new grant, the pointer SHALL become (winner index + 1) mod IN_SIZE.
REQ-014 BUSY: grant SHALL hold while req[owner] stays 1 and the hold counter is below MAX_HOLD.
REQ-015 BUSY, req[owner]=0 at an edge: if other requests are set, re-arbitrate at that edge and grant the new winner with no idle cycle; otherwise clear grant and enter IDLE.
REQ-016 Hold counter: cleared on each new grant and incremented each BUSY cycle while another req bit is set; it SHALL saturate at MAX_HOLD and SHALL stay frozen while no other request is pending.
REQ-017 Timeout: when the counter equals MAX_HOLD and another request is pending, the grant SHALL pass at that edge to the next winner after the owner; the owner's req bit is masked for that arbitration only.
REQ-018 A request raised in the same cycle as a hand-off SHALL take part in that hand-off's arbitration.
REQ-019 Grant SHALL never be asserted to a requester whose req bit was 0 at the granting edge.
REQ-020 grant_idx SHALL be derived combinationally from the registered grant, so grant and grant_idx change in the same cycle.
REQ-021 Starvation bound: any continuously asserted request SHALL be granted within (IN_SIZE-1)*(MAX_HOLD+1)+1 cycles.

Reset
REQ-022 With rst high at an edge: grant=0, grant_valid=0, grant_idx=0, state=IDLE, pointer=0, hold counter=0.
REQ-023 Reset asserted mid-grant SHALL drop the grant at that edge; req is ignored while rst is high.
REQ-024 The first arbitration after reset SHALL use pointer 0, so the lowest set index wins.

Structure
REQ-025 Package arbiter_pkg SHALL hold the state enum (IDLE, BUSY) and the hold counter width constant (8 bits).
REQ-026 grant_idx SHALL come from one instance of the team's existing one-hot-to-binary module encoder, with OUT_SIZE passed through.
REQ-027 Round-robin selection SHALL be a function or a double-width masked priority scan inside rr_arbiter; no other sub-modules.

Verification
REQ-028 All scenarios use OUT_SIZE=4, MAX_HOLD=8, and checks on every cycle assert that grant is one-hot or zero and that grant_idx matches grant.
REQ-029 Reset, then req=0x0001 -> next cycle grant=0x0001, grant_idx=0; drop req -> next cycle grant=0, grant_valid=0.
REQ-030 req=0xFFFF, each owner drops its req one cycle after its grant -> grant_idx sequence 0,1,2,...,15,0 with no gap cycles.
REQ-031 Timeout: req=0x0005 held constant -> idx 0 for 9 cycles, then idx 2 for 9 cycles, then idx 0, repeating.
REQ-032 Single requester req=0x8000 held for 50 cycles -> grant stays 0x8000 throughout with no timeout.
REQ-033 Wrap-around and reset: owner idx 15 drops its req while req[3] is set -> idx 3; assert rst during that grant -> grant=0, and the next arbitration with req=0x0018 -> idx 3.
